// File: rtl/divide.sv
// rtl/divide.sv - sequential restoring divider, 2N-bit by N-bit, one quotient bit per clock
// Start/busy/done handshake; divide-by-zero and quotient overflow are reported without iterating.
module divide #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  p_q, p_d;
  logic [N-1:0]  s_q, s_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;

  logic [N:0]    t;
  logic          ge;
  logic [N-1:0]  a_hi;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    p_d     = p_q;
    s_d     = s_q;
    q_d     = q_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    a_hi    = dividend[2*N-1:N];
    t       = {p_q, s_q[N-1]};
    ge      = (t >= {1'b0, d_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((divisor == '0) || (a_hi >= divisor)) begin
            state_d = DONE;
            dz_d    = (divisor == '0);
            ov_d    = (divisor != '0) && (a_hi >= divisor);
            quo_d   = '0;
            rem_d   = '0;
          end else begin
            state_d = CALC;
            d_d     = divisor;
            p_d     = a_hi;
            s_d     = dividend[N-1:0];
            q_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        // After a successful subtract the partial remainder is below D, so N bits hold it.
        p_d   = ge ? (t[N-1:0] - d_q) : t[N-1:0];
        s_d   = s_q << 1;
        q_d   = {q_q[N-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = p_d;
          dz_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      q_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      p_q     <= p_d;
      s_q     <= s_d;
      q_q     <= q_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_divide.sv
// tb/tb_divide.sv - self-checking bench for divide: directed table, exhaustive sweep, random ops
// Expected results come from plain integer division and the error-flag rules.
module tb_divide;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_zero, overflow;
  logic [3:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  divide #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: integer division, with the error cases returning zeros.
  task automatic model(input int a, input int b, output int q, output int r,
                       output int dz, output int ov, output int lat);
    dz = (b == 0);
    ov = (b != 0) && ((a / 16) >= b);
    if (dz || ov) begin
      q = 0; r = 0; lat = 0;
    end else begin
      q = a / b; r = a % b; lat = 4;
    end
  endtask

  // noise: 0 none, 1 start with A=50/B=3 while busy, 2 random start/operands while busy
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int noise,
                       output int lat, output int bcyc, output int q, output int r,
                       output int dz, output int ov, output int ok, output int busy_after);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    lat = 0; bcyc = 0; ok = 0; q = 0; r = 0; dz = 0; ov = 0; busy_after = 1;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcyc++;
      if (done) begin
        q = quotient; r = remainder; dz = div_zero; ov = overflow; ok = 1;
        start = 1'b0;
        break;
      end
      if (noise == 1) begin
        start = 1'b1; dividend = 8'd50; divisor = 4'd3;
      end else if (noise == 2) begin
        start = 1'($urandom); dividend = 8'($urandom); divisor = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    dividend = 8'($urandom);
    @(negedge clk);
    busy_after = (busy | done) ? 1 : 0;
    if (ok == 1 && (quotient !== 4'(q) || remainder !== 4'(r))) busy_after = 2;
  endtask

  initial begin
    int lat, bcyc, q, r, dz, ov, ok, ba;
    int eq, er, edz, eov, elat, bad;
    logic [7:0] ra;
    logic [3:0] rb;

    vt[0] = '{8'd100, 4'd7,  4'd14, 4'd2, 1'b0, 1'b0, 4};
    vt[1] = '{8'd225, 4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 4};
    vt[2] = '{8'hFF,  4'd15, 4'd0,  4'd0, 1'b0, 1'b1, 0};
    vt[3] = '{8'd37,  4'd0,  4'd0,  4'd0, 1'b1, 1'b0, 0};
    vt[4] = '{8'd100, 4'd7,  4'd14, 4'd2, 1'b0, 1'b0, 4};
    vt[5] = '{8'd0,   4'd5,  4'd0,  4'd0, 1'b0, 1'b0, 4};
    vt[6] = '{8'h5F,  4'd6,  4'd15, 4'd5, 1'b0, 1'b0, 4};
    vt[7] = '{8'h70,  4'd7,  4'd0,  4'd0, 1'b0, 1'b1, 0};
    vt[8] = '{8'd1,   4'd1,  4'd1,  4'd0, 1'b0, 1'b0, 4};

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_flags", {div_zero, overflow}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].a, vt[i].b, 0, lat, bcyc, q, r, dz, ov, ok, ba);
      chk($sformatf("vec%0d_done_seen", i), ok, 1);
      chk($sformatf("vec%0d_quotient", i), q, int'(vt[i].q));
      chk($sformatf("vec%0d_remainder", i), r, int'(vt[i].r));
      chk($sformatf("vec%0d_div_zero", i), dz, int'(vt[i].dz));
      chk($sformatf("vec%0d_overflow", i), ov, int'(vt[i].ov));
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcyc, vt[i].lat + 1);
      chk($sformatf("vec%0d_idle_hold", i), ba, 0);
    end

    // Start requests during CALC must be ignored.
    do_op(8'd100, 4'd7, 1, lat, bcyc, q, r, dz, ov, ok, ba);
    chk("ignore_start_quotient", q, 14);
    chk("ignore_start_remainder", r, 2);
    chk("ignore_start_latency", lat, 4);

    // Reset mid-CALC discards the request.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_busy", busy, 0);
    chk("midreset_outputs", {done, quotient, remainder, div_zero, overflow}, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("midreset_no_done", bad, 0);

    // Every legal (A,B) pair.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(8'(a), 4'(b), 0, lat, bcyc, q, r, dz, ov, ok, ba);
        model(a, b, eq, er, edz, eov, elat);
        chk($sformatf("sweep_a%0d_b%0d", a, b),
            {ok, q, r, dz, ov, lat, ba}, {1, eq, er, edz, eov, elat, 0});
        if (ok == 1 && edz == 0 && eov == 0)
          chk($sformatf("sweep_inv_a%0d_b%0d", a, b), ((q * b + r) == a && r < b) ? 1 : 0, 1);
      end
    end

    // Random operands with random start noise while busy.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 4'($urandom);
      if ($urandom_range(0, 3) == 0) ra[7:4] = rb - 4'd1;
      do_op(ra, rb, 2, lat, bcyc, q, r, dz, ov, ok, ba);
      model(int'(ra), int'(rb), eq, er, edz, eov, elat);
      chk($sformatf("rand%0d_a%0d_b%0d", i, ra, rb),
          {ok, q, r, dz, ov, lat, bcyc}, {1, eq, er, edz, eov, elat, elat + 1});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
